// File: rtl/smooth_pkg.sv
// Shared defaults, coordinate widths and FSM encoding for the smoothing-border aligner.
package smooth_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int LAT_DEF      = 4;
    localparam int DATA_W       = 10;
    localparam int OX_W         = 11;
    localparam int OY_W         = 10;
    localparam logic [DATA_W-1:0] BORDER_VAL_DEF = 10'h000;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DONE     = 2'd2
    } state_e;
endpackage

// File: rtl/strobe_delay.sv
// Fixed-depth shift register that delays a small strobe bundle by DEPTH clocks.
module strobe_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/smooth_border_align.sv
// Realigns delayed smoothing-stage strobes into framed pixel coordinates and
// replaces pixels whose 3x3 window is incomplete with BORDER_VAL.
module smooth_border_align
    import smooth_pkg::*;
#(
    parameter int                H_ACTIVE   = H_ACTIVE_DEF,
    parameter int                V_ACTIVE   = V_ACTIVE_DEF,
    parameter int                LAT        = LAT_DEF,
    parameter logic [DATA_W-1:0] BORDER_VAL = BORDER_VAL_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              idata_valid,
    input  logic              iframe_start,
    input  logic [DATA_W-1:0] data_in,
    output logic              odata_valid,
    output logic [DATA_W-1:0] data_o,
    output logic [OX_W-1:0]   ox,
    output logic [OY_W-1:0]   oy,
    output logic              oline_end,
    output logic              oframe_end,
    output logic              ofrm_err,
    output state_e            state_dbg_o
);
    localparam logic [OX_W-1:0] X_LAST = OX_W'(H_ACTIVE - 1);
    localparam logic [OY_W-1:0] Y_LAST = OY_W'(V_ACTIVE - 1);

    logic [1:0] dly;
    logic       dv, dsof;

    strobe_delay #(.DEPTH(LAT), .WIDTH(2)) u_strobe_delay (
        .clk_i  (clk_in),
        .rst_ni (rst_n),
        .d_i    ({iframe_start, idata_valid}),
        .q_o    (dly)
    );
    assign dv   = dly[0];
    assign dsof = dly[1];

    state_e            state_q, state_d;
    logic [OX_W-1:0]   ox_q, ox_d, nx_x, px;
    logic [OY_W-1:0]   oy_q, oy_d, nx_y, py;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, le_q, le_d, fe_q, fe_d, err_q, err_d;
    logic              emit, is_last;

    always_comb begin
        nx_x    = (ox_q == X_LAST) ? '0 : ox_q + OX_W'(1);
        nx_y    = (ox_q == X_LAST) ? oy_q + OY_W'(1) : oy_q;
        emit    = 1'b0;
        px      = '0;
        py      = '0;
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_WAIT_SOF: begin
                if (dv && dsof) begin
                    emit    = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (dv) begin
                    emit = 1'b1;
                    // A restart mid-frame is flagged but the new frame is honoured from (0,0).
                    if (dsof) begin
                        err_d = 1'b1;
                    end else begin
                        px = nx_x;
                        py = nx_y;
                    end
                end
            end
            ST_DONE: begin
                if (dv) begin
                    if (dsof) begin
                        emit    = 1'b1;
                        state_d = ST_ACTIVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_WAIT_SOF;
        endcase

        is_last = (px == X_LAST) && (py == Y_LAST);
        if (emit && is_last) state_d = ST_DONE;

        ox_d    = ox_q;
        oy_d    = oy_q;
        data_d  = data_q;
        valid_d = emit;
        le_d    = 1'b0;
        fe_d    = 1'b0;
        if (emit) begin
            ox_d   = px;
            oy_d   = py;
            data_d = (px < OX_W'(2) || py < OY_W'(2)) ? BORDER_VAL : data_in;
            le_d   = (px == X_LAST);
            fe_d   = is_last;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_SOF;
            ox_q    <= '0;
            oy_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            le_q    <= 1'b0;
            fe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            le_q    <= le_d;
            fe_q    <= fe_d;
            err_q   <= err_d;
        end
    end

    assign odata_valid = valid_q;
    assign data_o      = data_q;
    assign ox          = ox_q;
    assign oy          = oy_q;
    assign oline_end   = le_q;
    assign oframe_end  = fe_q;
    assign ofrm_err    = err_q;
    assign state_dbg_o = state_q;
endmodule

// File: tb/tb_smooth_border_align.sv
// Randomised bench for smooth_border_align against a linear-pixel-index frame model.
module tb_smooth_border_align;
    import smooth_pkg::*;

    localparam int H    = 8;
    localparam int V    = 6;
    localparam int LAT  = 4;
    localparam int N    = H * V;
    localparam int MAXC = 4096;
    localparam logic [9:0] BVAL = 10'h000;

    logic       clk_in = 1'b0;
    logic       rst_n, idata_valid, iframe_start;
    logic [9:0] data_in;
    logic       odata_valid, oline_end, oframe_end, ofrm_err;
    logic [9:0] data_o;
    logic [10:0] ox;
    logic [9:0] oy;
    state_e     state_dbg;

    smooth_border_align #(.H_ACTIVE(H), .V_ACTIVE(V), .LAT(LAT), .BORDER_VAL(BVAL)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .idata_valid  (idata_valid),
        .iframe_start (iframe_start),
        .data_in      (data_in),
        .odata_valid  (odata_valid),
        .data_o       (data_o),
        .ox           (ox),
        .oy           (oy),
        .oline_end    (oline_end),
        .oframe_end   (oframe_end),
        .ofrm_err     (ofrm_err),
        .state_dbg_o  (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    // stimulus history indexed by negedge number
    bit in_v [MAXC];
    bit in_s [MAXC];
    int in_d [MAXC];
    bit rst_h[MAXC];
    int cyc;

    // model: mode 0 = waiting for first frame, 1 = in frame, 2 = frame complete
    int m_mode, m_pos;
    int e_valid, e_data, e_ox, e_oy, e_le, e_fe, e_err;

    int total, bad;
    int n_valid, n_le, n_fe, n_155, n_zero, first_valid, first_ox, first_oy, first_data, fe_x, fe_y;
    int v_ox[$];
    int v_oy[$];
    int data_const;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_valid = 0; n_le = 0; n_fe = 0; n_155 = 0; n_zero = 0;
        first_valid = -1; first_ox = -1; first_oy = -1; first_data = -1;
        fe_x = -1; fe_y = -1;
        v_ox.delete(); v_oy.delete();
    endtask

    task automatic model_emit(int c);
        int x, y;
        x = m_pos % H;
        y = m_pos / H;
        e_valid = 1;
        e_ox = x;
        e_oy = y;
        e_data = (x >= 2 && y >= 2) ? in_d[c-1] : int'(BVAL);
        e_le = (x == H - 1) ? 1 : 0;
        e_fe = (m_pos == N - 1) ? 1 : 0;
        m_pos++;
        if (e_fe != 0) m_mode = 2;
    endtask

    task automatic model_step(int c);
        int s;
        bit live;
        if (rst_h[c-1]) begin
            m_mode = 0; m_pos = 0;
            e_valid = 0; e_data = 0; e_ox = 0; e_oy = 0; e_le = 0; e_fe = 0; e_err = 0;
        end else begin
            e_valid = 0; e_le = 0; e_fe = 0;
            s = c - LAT - 1;
            if (s >= 0 && in_v[s]) begin
                live = 1'b1;
                for (int k = s; k < c; k++) if (rst_h[k]) live = 1'b0;
                if (live) begin
                    if (in_s[s]) begin
                        if (m_mode == 1) e_err = 1;
                        m_pos = 0;
                        m_mode = 1;
                        model_emit(c);
                    end else if (m_mode == 1) begin
                        model_emit(c);
                    end else if (m_mode == 2) begin
                        e_err = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare(int c);
        chk("odata_valid", int'(odata_valid), e_valid);
        chk("ox", int'(ox), e_ox);
        chk("oy", int'(oy), e_oy);
        chk("data_o", int'(data_o), e_data);
        chk("oline_end", int'(oline_end), e_le);
        chk("oframe_end", int'(oframe_end), e_fe);
        chk("ofrm_err", int'(ofrm_err), e_err);
        if (odata_valid) begin
            n_valid++;
            v_ox.push_back(int'(ox));
            v_oy.push_back(int'(oy));
            if (first_valid < 0) begin
                first_valid = c; first_ox = int'(ox); first_oy = int'(oy); first_data = int'(data_o);
            end
            if (data_o == 10'h155) n_155++;
            if (data_o == 10'h000) n_zero++;
        end
        if (oline_end) n_le++;
        if (oframe_end) begin
            n_fe++; fe_x = int'(ox); fe_y = int'(oy);
        end
    endtask

    task automatic tick(bit v, bit s, bit r);
        int d;
        @(negedge clk_in);
        cyc++;
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        model_step(cyc);
        compare(cyc);
        d = (data_const >= 0) ? data_const : int'($urandom_range(0, 1023));
        idata_valid = v; iframe_start = s; data_in = d[9:0]; rst_n = ~r;
        in_v[cyc] = v; in_s[cyc] = s; in_d[cyc] = d; rst_h[cyc] = r;
    endtask

    task automatic pixel(bit s, int gap);
        tick(1'b1, s, 1'b0);
        repeat (gap) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(int gap);
        pixel(1'b1, gap);
        for (int i = 1; i < N; i++) pixel(1'b0, gap);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; data_const = -1;
        m_mode = 0; m_pos = 0;
        e_valid = 0; e_data = 0; e_ox = 0; e_oy = 0; e_le = 0; e_fe = 0; e_err = 0;
        rst_n = 1'b0; idata_valid = 1'b0; iframe_start = 1'b0; data_in = '0;
        in_v[0] = 0; in_s[0] = 0; in_d[0] = 0; rst_h[0] = 1;
        clear_stats();

        // reset, then a back-to-back frame launched at cycle 10
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        idle(6);
        clear_stats();
        send_frame(0);
        idle(8);
        chk("first_valid_cycle", first_valid, 15);
        chk("first_ox", first_ox, 0);
        chk("first_oy", first_oy, 0);
        chk("first_data", first_data, 0);
        chk("frame_pixels", n_valid, 48);
        chk("frame_end_count", n_fe, 1);
        chk("frame_end_x", fe_x, 7);
        chk("frame_end_y", fe_y, 5);

        // constant input exposes the border mask
        data_const = 'h155;
        clear_stats();
        send_frame(0);
        idle(8);
        chk("border_inner_count", n_155, 24);
        chk("border_edge_count", n_zero, 24);
        chk("border_pixels", n_valid, 48);
        data_const = -1;

        // one strobe every 3 cycles
        clear_stats();
        send_frame(2);
        idle(8);
        chk("gapped_pixels", n_valid, 48);
        chk("gapped_line_ends", n_le, 6);
        chk("gapped_err", int'(ofrm_err), 0);

        // restart after 20 pixels
        clear_stats();
        pixel(1'b1, 0);
        for (int i = 1; i < 20; i++) pixel(1'b0, 0);
        send_frame(0);
        idle(8);
        chk("restart_err", int'(ofrm_err), 1);
        chk("restart_pixels", n_valid, 68);
        chk("restart_frame_ends", n_fe, 1);
        if (v_ox.size() >= 21) begin
            chk("restart_pre_x", v_ox[19], 3);
            chk("restart_pre_y", v_oy[19], 2);
            chk("restart_x", v_ox[20], 0);
            chk("restart_y", v_oy[20], 0);
        end else begin
            chk("restart_have_21", v_ox.size(), 21);
        end

        // orphan strobes after the frame completed
        clear_stats();
        for (int i = 0; i < 5; i++) pixel(1'b0, 0);
        idle(8);
        chk("orphan_pixels", n_valid, 0);
        chk("orphan_err", int'(ofrm_err), 1);

        // reset clears the sticky flag; then abandon a frame at pixel 30
        tick(1'b0, 1'b0, 1'b1);
        idle(3);
        chk("reset_clears_err", int'(ofrm_err), 0);
        pixel(1'b1, 0);
        for (int i = 1; i < 30; i++) pixel(1'b0, 0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("midreset_valid", int'(odata_valid), 0);
        chk("midreset_ox", int'(ox), 0);
        chk("midreset_oy", int'(oy), 0);
        chk("midreset_data", int'(data_o), 0);
        chk("midreset_err", int'(ofrm_err), 0);
        clear_stats();
        for (int i = 0; i < 5; i++) pixel(1'b0, 0);
        idle(8);
        chk("post_reset_orphans", n_valid, 0);
        clear_stats();
        send_frame(0);
        idle(8);
        chk("post_reset_pixels", n_valid, 48);
        chk("post_reset_first_x", first_ox, 0);
        chk("post_reset_first_y", first_oy, 0);
        chk("post_reset_err", int'(ofrm_err), 0);

        // random gaps between strobes
        clear_stats();
        pixel(1'b1, int'($urandom_range(0, 3)));
        for (int i = 1; i < N; i++) pixel(1'b0, int'($urandom_range(0, 3)));
        idle(8);
        chk("random_pixels", n_valid, 48);
        chk("random_line_ends", n_le, 6);
        chk("random_frame_ends", n_fe, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
